// File: rtl/seven_seg_decoder_monitor.sv
// ---------------------------------------------------------------------------
// seven_seg_decoder_monitor
//
// Receive-side checker for a 7-segment display path. The active-low segment
// bus is synchronized, debounced (a new pattern must hold for STABLE_CYCLES
// synchronized cycles), decoded back to a decimal digit, and checked against
// the 0..9 wrap-around count sequence.
//
// Parameters:
//   STABLE_CYCLES  cycles a new pattern must hold before it is committed (>= 2)
//   CNT_W          width of the settle counter
//
// Ports:
//   i_Clk          system clock
//   i_Rst_L        synchronous reset, active-low
//   i_Segments     active-low pattern, bit6=A .. bit0=G
//   o_Digit        last committed digit (holds between commits)
//   o_Digit_Valid  one-cycle strobe: a digit was committed
//   o_Blank        level: committed pattern is all segments off
//   o_Invalid      one-cycle strobe: committed pattern is not a digit or blank
//   o_Seq_Error    one-cycle strobe with o_Digit_Valid: digit is out of sequence
//   o_Error_Count  saturating count of o_Invalid + o_Seq_Error events
// ---------------------------------------------------------------------------
module seven_seg_decoder_monitor #(
  parameter int STABLE_CYCLES = 250000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] i_Segments,
  output logic [3:0] o_Digit,
  output logic       o_Digit_Valid,
  output logic       o_Blank,
  output logic       o_Invalid,
  output logic       o_Seq_Error,
  output logic [7:0] o_Error_Count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Maps an active-high ABCDEFG pattern to {is_digit, digit}.
  function automatic logic [4:0] decode_pattern(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h7E:   res = {1'b1, 4'd0};
      7'h30:   res = {1'b1, 4'd1};
      7'h6D:   res = {1'b1, 4'd2};
      7'h79:   res = {1'b1, 4'd3};
      7'h33:   res = {1'b1, 4'd4};
      7'h5B:   res = {1'b1, 4'd5};
      7'h5F:   res = {1'b1, 4'd6};
      7'h70:   res = {1'b1, 4'd7};
      7'h7F:   res = {1'b1, 4'd8};
      7'h7B:   res = {1'b1, 4'd9};
      default: res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  // Decimal successor with 9 -> 0 wrap.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    logic [3:0] res;
    if (d == 4'd9) begin
      res = 4'd0;
    end else begin
      res = d + 4'd1;
    end
    return res;
  endfunction

  // Synchronizer and active-high view of the bus
  logic [6:0] sync1_r;
  logic [6:0] sync2_r;
  logic [6:0] pattern_s;

  // FSM state and settle tracking
  state_t     state_r;
  state_t     state_nxt_s;
  logic [6:0] cand_r;
  logic [6:0] cand_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [6:0] committed_r;
  logic [6:0] committed_nxt_s;

  // Sequence tracking
  logic [3:0] prev_r;
  logic [3:0] prev_nxt_s;
  logic       prev_valid_r;
  logic       prev_valid_nxt_s;

  // Registered outputs
  logic [3:0] digit_r;
  logic [3:0] digit_nxt_s;
  logic       digit_valid_r;
  logic       digit_valid_nxt_s;
  logic       blank_r;
  logic       blank_nxt_s;
  logic       invalid_r;
  logic       invalid_nxt_s;
  logic       seq_error_r;
  logic       seq_error_nxt_s;
  logic [7:0] err_count_r;
  logic [7:0] err_count_nxt_s;

  // Decode of the candidate about to be committed
  logic       commit_s;
  logic [4:0] dec_s;
  logic       dec_is_digit_s;
  logic [3:0] dec_digit_s;

  assign pattern_s      = ~sync2_r;
  assign dec_s          = decode_pattern(cand_r);
  assign dec_is_digit_s = dec_s[4];
  assign dec_digit_s    = dec_s[3:0];

  // Two-flop synchronizer; reset value is "all segments off"
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_r <= 7'h7F;
      sync2_r <= 7'h7F;
    end else begin
      sync1_r <= i_Segments;
      sync2_r <= sync1_r;
    end
  end

  // Next-state, settle counter and commit-time output computation
  always_comb begin
    state_nxt_s       = state_r;
    cand_nxt_s        = cand_r;
    cnt_nxt_s         = cnt_r;
    committed_nxt_s   = committed_r;
    prev_nxt_s        = prev_r;
    prev_valid_nxt_s  = prev_valid_r;
    digit_nxt_s       = digit_r;
    blank_nxt_s       = blank_r;
    digit_valid_nxt_s = 1'b0;
    invalid_nxt_s     = 1'b0;
    seq_error_nxt_s   = 1'b0;
    err_count_nxt_s   = err_count_r;
    commit_s          = 1'b0;

    case (state_r)
      ST_WAIT: begin
        if (pattern_s != committed_r) begin
          cand_nxt_s  = pattern_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_SETTLE: begin
        if (pattern_s == committed_r) begin
          // Bus went back to what is already committed: a glitch, drop it.
          state_nxt_s = ST_WAIT;
        end else if (pattern_s != cand_r) begin
          // Still moving: restart the settle window on the new value.
          cand_nxt_s = pattern_s;
          cnt_nxt_s  = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          // Outputs are loaded on this edge so they are valid in COMMIT.
          state_nxt_s = ST_COMMIT;
          commit_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        state_nxt_s = ST_WAIT;
      end
      default: begin
        state_nxt_s = ST_WAIT;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase

    if (commit_s) begin
      committed_nxt_s = cand_r;
      if (cand_r == 7'h00) begin
        // Blank: no strobe, digit and sequence history untouched.
        blank_nxt_s = 1'b1;
      end else if (dec_is_digit_s) begin
        digit_nxt_s       = dec_digit_s;
        digit_valid_nxt_s = 1'b1;
        blank_nxt_s       = 1'b0;
        if (prev_valid_r && (dec_digit_s != next_digit(prev_r))) begin
          seq_error_nxt_s = 1'b1;
        end else begin
          seq_error_nxt_s = 1'b0;
        end
        prev_nxt_s       = dec_digit_s;
        prev_valid_nxt_s = 1'b1;
      end else begin
        invalid_nxt_s = 1'b1;
        blank_nxt_s   = 1'b0;
      end
    end else begin
      committed_nxt_s = committed_r;
    end

    // Invalid and sequence error cannot coincide, so one increment suffices.
    if ((invalid_nxt_s || seq_error_nxt_s) && (err_count_r != 8'hFF)) begin
      err_count_nxt_s = err_count_r + 8'd1;
    end else begin
      err_count_nxt_s = err_count_r;
    end
  end

  // State, tracking and output registers
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_r       <= ST_WAIT;
      cand_r        <= 7'h00;
      cnt_r         <= {CNT_W{1'b0}};
      committed_r   <= 7'h00;
      prev_r        <= 4'd0;
      prev_valid_r  <= 1'b0;
      digit_r       <= 4'd0;
      digit_valid_r <= 1'b0;
      blank_r       <= 1'b1;
      invalid_r     <= 1'b0;
      seq_error_r   <= 1'b0;
      err_count_r   <= 8'd0;
    end else begin
      state_r       <= state_nxt_s;
      cand_r        <= cand_nxt_s;
      cnt_r         <= cnt_nxt_s;
      committed_r   <= committed_nxt_s;
      prev_r        <= prev_nxt_s;
      prev_valid_r  <= prev_valid_nxt_s;
      digit_r       <= digit_nxt_s;
      digit_valid_r <= digit_valid_nxt_s;
      blank_r       <= blank_nxt_s;
      invalid_r     <= invalid_nxt_s;
      seq_error_r   <= seq_error_nxt_s;
      err_count_r   <= err_count_nxt_s;
    end
  end

  assign o_Digit       = digit_r;
  assign o_Digit_Valid = digit_valid_r;
  assign o_Blank       = blank_r;
  assign o_Invalid     = invalid_r;
  assign o_Seq_Error   = seq_error_r;
  assign o_Error_Count = err_count_r;

endmodule

// File: tb/tb_seven_seg_decoder_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for seven_seg_decoder_monitor (STABLE_CYCLES = 4).
// Stimulus pushes expected strobe events and level snapshots into queues;
// a monitor on the falling clock edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_seven_seg_decoder_monitor;

  localparam int STABLE = 4;
  localparam int LIMIT  = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       invalid;
  logic       seq_error;
  logic [7:0] error_count;

  typedef struct {
    bit is_inv;
    int digit;
    bit seq;
    int cnt;
  } strobe_t;

  typedef struct {
    int digit;
    bit blank;
    int cnt;
    bit valid;
  } level_t;

  strobe_t sb_q[$];
  level_t  lvl_q[$];

  int checks = 0;
  int errors = 0;
  int cycles = 0;
  bit done   = 1'b0;

  seven_seg_decoder_monitor #(.STABLE_CYCLES(STABLE)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Segments    (seg),
    .o_Digit       (digit),
    .o_Digit_Valid (digit_valid),
    .o_Blank       (blank),
    .o_Invalid     (invalid),
    .o_Seq_Error   (seq_error),
    .o_Error_Count (error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares strobes against the scoreboard and level snapshots
  always @(negedge clk) begin
    strobe_t e;
    level_t  l;
    cycles++;
    if (digit_valid || invalid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: actual valid=%0d invalid=%0d digit=%0d required no strobe (t=%0t)",
                 digit_valid, invalid, digit, $time);
      end else begin
        e = sb_q.pop_front();
        check("strobe_invalid", invalid, e.is_inv);
        check("strobe_valid", digit_valid, !e.is_inv);
        check("strobe_digit", digit, e.digit);
        check("strobe_seq_error", seq_error, e.seq);
        check("strobe_err_count", error_count, e.cnt);
        check("strobe_blank", blank, 0);
      end
    end
    while (lvl_q.size() > 0) begin
      l = lvl_q.pop_front();
      check("level_digit", digit, l.digit);
      check("level_blank", blank, l.blank);
      check("level_err_count", error_count, l.cnt);
      check("level_valid", digit_valid, l.valid);
    end
    if (done) begin
      check("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (cycles > LIMIT) begin
      checks++;
      errors++;
      $display("FAIL timeout: actual cycles=%0d required at most %0d", cycles, LIMIT);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic exp_digit(input int d, input bit seq, input int cnt);
    strobe_t e;
    e.is_inv = 1'b0; e.digit = d; e.seq = seq; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic exp_inv(input int d, input int cnt);
    strobe_t e;
    e.is_inv = 1'b1; e.digit = d; e.seq = 1'b0; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic exp_level(input int d, input bit b, input int cnt, input bit v);
    level_t l;
    l.digit = d; l.blank = b; l.cnt = cnt; l.valid = v;
    lvl_q.push_back(l);
  endtask

  // Called just after a rising edge; leaves just after a rising edge.
  task automatic hold(input logic [6:0] pat, input int n);
    seg = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Active-low patterns for digits 1..9 then 0
  logic [6:0] seq_pat [10] = '{7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24,
                               7'h20, 7'h0F, 7'h00, 7'h04, 7'h01};
  int         seq_dig [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

  initial begin
    int cnt;
    rst_n = 1'b0;
    seg   = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_level(0, 1'b1, 0, 1'b0);

    // First digit: strobe exactly in the cycle after edge 6
    exp_digit(0, 1'b0, 0);
    seg = 7'h01;
    repeat (6) @(posedge clk);
    #1;
    exp_level(0, 1'b1, 0, 1'b0);
    @(posedge clk);
    #1;
    exp_level(0, 1'b0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Full count 1..9, wrap to 0: no sequence errors
    for (int i = 0; i < 10; i++) begin
      exp_digit(seq_dig[i], 1'b0, 0);
      hold(seq_pat[i], 10);
    end
    exp_level(0, 1'b0, 0, 1'b0);

    // 0 -> 2 skips a digit
    exp_digit(2, 1'b1, 1);
    hold(7'h12, 10);
    exp_digit(3, 1'b0, 1);
    hold(7'h06, 10);

    // Glitch back to committed pattern: no strobe
    hold(7'h4C, 2);
    hold(7'h06, 10);
    exp_level(3, 1'b0, 1, 1'b0);

    // Candidate changes mid-settle: only 5 commits (3 -> 5 out of sequence)
    exp_digit(5, 1'b1, 2);
    hold(7'h4C, 3);
    hold(7'h24, 10);

    // Invalid pattern
    exp_inv(5, 3);
    hold(7'h7E, 10);

    // 300 more error events: count saturates at 255
    cnt = 3;
    for (int i = 0; i < 150; i++) begin
      cnt = (cnt < 255) ? cnt + 1 : 255;
      exp_digit(5, 1'b1, cnt);
      hold(7'h24, 8);
      cnt = (cnt < 255) ? cnt + 1 : 255;
      exp_inv(5, cnt);
      hold(7'h7E, 8);
    end
    exp_level(5, 1'b0, 255, 1'b0);

    // Reset during SETTLE: no strobe, reset values, fresh history
    hold(7'h0F, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_level(0, 1'b1, 0, 1'b0);
    exp_digit(7, 1'b0, 0);
    hold(7'h0F, 12);

    // Blank commit: no strobe, digit held; same digit afterwards is an error
    hold(7'h7F, 10);
    exp_level(7, 1'b1, 0, 1'b0);
    exp_digit(7, 1'b1, 1);
    hold(7'h0F, 10);
    exp_level(7, 1'b0, 1, 1'b0);

    @(posedge clk);
    #1;
    done = 1'b1;
  end

endmodule
